// File: rtl/sample_rle_encoder_pkg.sv
// rtl/sample_rle_encoder_pkg.sv - shared state encoding and word constants for the RLE encoder/decoder
package sample_rle_encoder_pkg;

    localparam int WORD_W = 16;

    // A count word of RUN_CONT means 65535 more repeats, and another count word follows.
    localparam logic [WORD_W-1:0] RUN_CONT = 16'hFFFF;

    typedef enum logic [1:0] {
        LIT0 = 2'd0,
        LIT1 = 2'd1,
        RUN  = 2'd2
    } rle_state_t;

endpackage

// File: rtl/sample_rle_encoder_if.sv
// rtl/sample_rle_encoder_if.sv - sample input and encoded word output handshakes of the RLE encoder
interface sample_rle_encoder_if;
    import sample_rle_encoder_pkg::*;

    logic [WORD_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic              flush;
    logic [WORD_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;

    modport master (
        output in_data, in_valid, flush, out_ready,
        input  in_ready, out_data, out_valid
    );

    modport slave (
        input  in_data, in_valid, flush, out_ready,
        output in_ready, out_data, out_valid
    );
endinterface

// File: rtl/sample_rle_encoder_word_fifo.sv
// rtl/sample_rle_encoder_word_fifo.sv - word FIFO with two write ports per cycle and one read port
module encoder_word_fifo
    import sample_rle_encoder_pkg::*;
#(
    parameter int AW = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push0,
    input  logic [WORD_W-1:0] push0_data,
    input  logic              push1,
    input  logic [WORD_W-1:0] push1_data,
    input  logic              pop,
    output logic [WORD_W-1:0] rd_data,
    output logic              rd_valid,
    output logic [AW:0]       free
);

    localparam int DEPTH = 1 << AW;

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW-1:0]     wr_ptr1;
    logic [AW:0]       count;
    logic [AW:0]       n_push;
    logic              do_pop;

    // push1 is only ever asserted together with push0, so it lands in the slot after push0.
    assign wr_ptr1  = wr_ptr + 1'b1;
    assign n_push   = (AW+1)'(push0) + (AW+1)'(push1);
    assign do_pop   = pop & (count != '0);
    assign rd_valid = (count != '0);
    assign rd_data  = mem[rd_ptr];
    assign free     = (AW+1)'(DEPTH) - count;

    always_ff @(posedge clk) begin
        if (push0) mem[wr_ptr]  <= push0_data;
        if (push1) mem[wr_ptr1] <= push1_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            wr_ptr <= wr_ptr + n_push[AW-1:0];
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count  <= count + n_push - (AW+1)'(do_pop);
        end
    end

endmodule

// File: rtl/sample_rle_encoder.sv
// rtl/sample_rle_encoder.sv - run-length encoder for the 16-bit sample stream
module sample_rle_encoder
    import sample_rle_encoder_pkg::*;
#(
    parameter int FIFO_AW = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    sample_rle_encoder_if.slave  bus,
    output logic                 idle
);

    rle_state_t        state, state_n;
    logic [WORD_W-1:0] last, last_n;
    logic [WORD_W-1:0] run_cnt, cnt_n;
    logic [WORD_W-1:0] run_inc;
    logic [WORD_W-1:0] w0, w1;
    logic              push0, push1;
    logic              in_xfer;
    logic [FIFO_AW:0]  fifo_free;

    // Two free slots guarantee room for the worst-case pair of words from one input cycle.
    assign bus.in_ready = (fifo_free >= (FIFO_AW+1)'(2));
    assign in_xfer      = bus.in_valid & bus.in_ready;
    assign run_inc      = run_cnt + 16'd1;
    assign idle         = !bus.out_valid && (state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= LIT0;
            last    <= '0;
            run_cnt <= '0;
        end else begin
            state   <= state_n;
            last    <= last_n;
            run_cnt <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        last_n  = last;
        cnt_n   = run_cnt;
        push0   = 1'b0;
        push1   = 1'b0;
        w0      = bus.in_data;
        w1      = bus.in_data;

        if (in_xfer) begin
            case (state)
                LIT0: begin
                    push0   = 1'b1;
                    last_n  = bus.in_data;
                    state_n = LIT1;
                end
                LIT1: begin
                    push0  = 1'b1;
                    last_n = bus.in_data;
                    if (bus.in_data == last) begin
                        state_n = RUN;
                        cnt_n   = '0;
                    end
                end
                RUN: begin
                    if (bus.in_data == last) begin
                        if (run_inc == RUN_CONT) begin
                            push0 = 1'b1;
                            w0    = RUN_CONT;
                            cnt_n = '0;
                        end else begin
                            cnt_n = run_inc;
                        end
                    end else begin
                        push0   = 1'b1;
                        w0      = run_cnt;
                        push1   = 1'b1;
                        w1      = bus.in_data;
                        last_n  = bus.in_data;
                        state_n = LIT1;
                    end
                end
                default: state_n = LIT0;
            endcase
        end

        // Flush sees the state after this cycle's sample, so it may close a run that just opened.
        if (bus.flush && bus.in_ready && (state_n == RUN)) begin
            if (push0) begin
                push1 = 1'b1;
                w1    = cnt_n;
            end else begin
                push0 = 1'b1;
                w0    = cnt_n;
            end
            state_n = LIT0;
        end
    end

    encoder_word_fifo #(
        .AW (FIFO_AW)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push0      (push0),
        .push0_data (w0),
        .push1      (push1),
        .push1_data (w1),
        .pop        (bus.out_ready),
        .rd_data    (bus.out_data),
        .rd_valid   (bus.out_valid),
        .free       (fifo_free)
    );

endmodule

// File: tb/tb_sample_rle_encoder.sv
// tb/tb_sample_rle_encoder.sv - self-checking bench for sample_rle_encoder
module tb_sample_rle_encoder;
    import sample_rle_encoder_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    logic idle;

    sample_rle_encoder_if bus();

    sample_rle_encoder #(.FIFO_AW(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus),
        .idle  (idle)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [15:0] model_q [$];
    logic [15:0] cap_q   [$];
    logic [15:0] exp_lit [$];
    int          seg_len;
    logic [15:0] seg_val;
    int          dec_st;
    logic [15:0] dec_last;
    longint      dec_idx;
    longint      accepted;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Model: a segment is a maximal stretch of equal samples not split by a flush of an open run.
    task automatic model_close();
        if (seg_len >= 2) model_q.push_back(16'((seg_len - 2) % 65535));
        seg_len = 0;
    endtask

    task automatic model_sample(input logic [15:0] s);
        if (seg_len > 0 && s == seg_val) begin
            seg_len++;
        end else begin
            model_close();
            seg_val = s;
            seg_len = 1;
        end
        if (seg_len <= 2) model_q.push_back(s);
        else if ((seg_len - 2) % 65535 == 0) model_q.push_back(16'hFFFF);
    endtask

    task automatic decode(input logic [15:0] w);
        case (dec_st)
            0: begin dec_idx++; dec_last = w; dec_st = 1; end
            1: begin dec_idx++; if (w == dec_last) dec_st = 2; dec_last = w; end
            default: begin
                if (w == RUN_CONT) dec_idx += 65535;
                else begin dec_idx += longint'(w); dec_st = 0; end
            end
        endcase
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            model_q.delete();
            seg_len  = 0;
            dec_st   = 0;
            dec_idx  = 0;
            accepted = 0;
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                cap_q.push_back(bus.out_data);
                decode(bus.out_data);
                if (model_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL word_extra: got %h want no word", bus.out_data);
                end else begin
                    chk("word", bus.out_data, model_q.pop_front());
                end
            end
            if (bus.in_valid && bus.in_ready) begin
                accepted++;
                model_sample(bus.in_data);
            end
            if (bus.flush && bus.in_ready && seg_len >= 2) model_close();
        end
    end

    task automatic xfer(input logic v, input logic [15:0] s, input logic fl);
        int n = 0;
        bus.in_data  = s;
        bus.in_valid = v;
        bus.flush    = fl;
        @(negedge clk);
        while (!bus.in_ready && n < 1000) begin
            n++;
            @(negedge clk);
        end
        if (!bus.in_ready) begin
            total++;
            bad++;
            $display("FAIL xfer_timeout: got in_ready=0 want 1 within 1000 cycles");
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.flush    = 1'b0;
    endtask

    task automatic drain(input string name);
        int n = 0;
        @(negedge clk);
        while (!idle && n < 2000) begin
            n++;
            @(negedge clk);
        end
        chk({name, "_idle"}, idle, 1'b1);
        @(posedge clk);
        #1;
    endtask

    task automatic check_cap(input string name);
        chk({name, "_nwords"}, cap_q.size(), exp_lit.size());
        for (int i = 0; i < exp_lit.size() && i < cap_q.size(); i++)
            chk(name, cap_q[i], exp_lit[i]);
        chk({name, "_index"}, dec_idx, accepted);
        chk({name, "_model_left"}, model_q.size(), 0);
        cap_q.delete();
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.in_data   = '0;
        bus.in_valid  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", bus.out_valid, 1'b0);
        chk("rst_in_ready", bus.in_ready, 1'b1);
        chk("rst_idle", idle, 1'b1);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: distinct literals
        xfer(1, 16'h0001, 0); xfer(1, 16'h0002, 0); xfer(1, 16'h0003, 0);
        drain("t1");
        exp_lit = '{16'h0001, 16'h0002, 16'h0003};
        check_cap("t1");

        // 2: run closed by a new literal (two words pushed together)
        xfer(1, 16'h0005, 0); xfer(1, 16'h0005, 0); xfer(1, 16'h0005, 0);
        xfer(1, 16'h0005, 0); xfer(1, 16'h0007, 0);
        drain("t2");
        exp_lit = '{16'h0005, 16'h0005, 16'h0002, 16'h0007};
        check_cap("t2");

        // 3: flush while in LIT1 does nothing
        xfer(1, 16'h0005, 0); xfer(1, 16'h0005, 0); xfer(1, 16'h0009, 0);
        xfer(0, 16'h0000, 1);
        drain("t3");
        exp_lit = '{16'h0005, 16'h0005, 16'h0000, 16'h0009};
        check_cap("t3");

        // 4: long run with a continuation word, closed by flush
        for (int i = 0; i < 70000; i++) xfer(1, 16'h000A, 0);
        xfer(0, 16'h0000, 1);
        drain("t4");
        exp_lit = '{16'h000A, 16'h000A, 16'hFFFF, 16'h116F};
        check_cap("t4");

        // 5: count lands exactly on the continuation boundary
        for (int i = 0; i < 65537; i++) xfer(1, 16'h000A, 0);
        xfer(1, 16'h0003, 0);
        drain("t5");
        exp_lit = '{16'h000A, 16'h000A, 16'hFFFF, 16'h0000, 16'h0003};
        check_cap("t5");

        // 6a: backpressure
        bus.out_ready = 1'b0;
        for (int i = 0; i < 3; i++) xfer(1, 16'(16 + i), 0);
        bus.in_data  = 16'h0013;
        bus.in_valid = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("stall_in_ready", bus.in_ready, 1'b0);
        end
        chk("stall_out_valid", bus.out_valid, 1'b1);
        chk("stall_head", bus.out_data, 16'h0010);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        xfer(1, 16'h0013, 0);
        drain("t6");
        exp_lit = '{16'h0010, 16'h0011, 16'h0012, 16'h0013};
        check_cap("t6");

        // 6b: reset in the middle of an open run
        bus.out_ready = 1'b0;
        xfer(1, 16'h0005, 0); xfer(1, 16'h0005, 0); xfer(1, 16'h0005, 0);
        @(negedge clk);
        chk("prerst_out_valid", bus.out_valid, 1'b1);
        chk("prerst_idle", idle, 1'b0);
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_out_valid", bus.out_valid, 1'b0);
        chk("midrst_idle", idle, 1'b1);
        chk("midrst_in_ready", bus.in_ready, 1'b1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.out_ready = 1'b1;
        cap_q.delete();
        xfer(1, 16'h0005, 0); xfer(1, 16'h0007, 0);
        xfer(0, 16'h0000, 1);
        drain("t7");
        exp_lit = '{16'h0005, 16'h0007};
        check_cap("t7");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
